// File: rtl/mq_ll_pkg.sv
// ---------------------------------------------------------------------------
// mq_ll_pkg
// Shared types and constants for the multi-queue linked-list pipe.
//   - *_DEF        : default parameter values of mq_linked_list_pipe
//   - ADDR_W       : node address width  ($clog2(LL_DEPTH))
//   - CNT_W        : occupancy width     ($clog2(LL_DEPTH+1))
//   - QID_W        : queue id width      ($clog2(NUM_QUEUES))
//   - ll_state_e   : INIT (free list build) / RUN
//   - deq_pipe_t   : one in-flight dequeue (valid, queue id, node address)
// Port and pointer widths of the top are taken from here, so a change of
// NUM_QUEUES or LL_DEPTH is made by editing the *_DEF values below.
// ---------------------------------------------------------------------------
package mq_ll_pkg;

  localparam int NUM_QUEUES_DEF = 4;
  localparam int LL_DEPTH_DEF   = 16;
  localparam int DATA_WIDTH_DEF = 4;
  localparam int READ_DELAY_DEF = 3;

  localparam int ADDR_W = $clog2(LL_DEPTH_DEF);
  localparam int CNT_W  = $clog2(LL_DEPTH_DEF + 1);
  localparam int QID_W  = $clog2(NUM_QUEUES_DEF);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ll_state_e;

  typedef struct packed {
    logic              vld;
    logic [QID_W-1:0]  qid;
    logic [ADDR_W-1:0] addr;
  } deq_pipe_t;

endpackage

// File: rtl/ll_delay_ram.sv
// ---------------------------------------------------------------------------
// ll_delay_ram
// Simple dual-port storage array (1 write, 1 read) with a DELAY-stage
// registered read path. Used once for the payload array and once for the
// next-pointer array of the linked list.
// Ports:
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address, sampled every cycle
//   rdata  : mem[raddr] as sampled DELAY cycles earlier
// A read and a write to the same address in one cycle return the old data.
// ---------------------------------------------------------------------------
module ll_delay_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4,
  parameter int DELAY = 3
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_pipe_q [DELAY];

  // First stage is the RAM output register itself.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rd_pipe_q[0] <= mem[raddr];
  end

  for (genvar gi = 1; gi < DELAY; gi++) begin : g_stage
    always_ff @(posedge clk) begin
      rd_pipe_q[gi] <= rd_pipe_q[gi-1];
    end
  end

  assign rdata = rd_pipe_q[DELAY-1];

endmodule

// File: rtl/mq_linked_list_pipe.sv
// ---------------------------------------------------------------------------
// mq_linked_list_pipe
// NUM_QUEUES FIFOs sharing one LL_DEPTH-node payload / next-pointer store.
// After reset a free list of all node addresses is built (one per cycle),
// then enqueue allocates a free node and links it at the queue tail, and
// dequeue reads the head node; the payload leaves READ_DELAY+1 cycles after
// acceptance and the node returns to the free list in that same cycle.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   init_done            : free list built, block operational
//   enq_vld_in/rdy_out   : enqueue handshake, enq_id_in / enq_data_in
//   deq_vld_in           : dequeue request for queue deq_id_in
//   deq_rdy_out[q]       : queue q may be dequeued this cycle
//   deq_vld_out/id/data  : dequeued payload (one-cycle pulse)
//   queue_cnt_out        : per-queue occupancy, CNT_W bits per queue
//   global_cnt_out       : nodes held, including nodes awaiting release
// Optional (macro MQ_LL_ERR_EN):
//   enq_ovf_err_out      : sticky, enqueue requested while not ready
//   deq_udf_err_out      : sticky, dequeue requested from an empty queue
// ---------------------------------------------------------------------------
module mq_linked_list_pipe
  import mq_ll_pkg::*;
#(
  parameter int NUM_QUEUES = NUM_QUEUES_DEF,
  parameter int LL_DEPTH   = LL_DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int READ_DELAY = READ_DELAY_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  output logic                        init_done,
  input  logic                        enq_vld_in,
  output logic                        enq_rdy_out,
  input  logic [QID_W-1:0]            enq_id_in,
  input  logic [DATA_WIDTH-1:0]       enq_data_in,
  input  logic                        deq_vld_in,
  output logic [NUM_QUEUES-1:0]       deq_rdy_out,
  input  logic [QID_W-1:0]            deq_id_in,
  output logic                        deq_vld_out,
  output logic [QID_W-1:0]            deq_id_out,
  output logic [DATA_WIDTH-1:0]       deq_data_out,
`ifdef MQ_LL_ERR_EN
  output logic                        enq_ovf_err_out,
  output logic                        deq_udf_err_out,
`endif
  output logic [NUM_QUEUES*CNT_W-1:0] queue_cnt_out,
  output logic [CNT_W-1:0]            global_cnt_out
);

  ll_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  init_cnt_q, init_cnt_d;
  logic               init_done_q, init_done_d;

  // Free list: circular FIFO of node addresses. Small, so it is read
  // combinationally to hand out an address in the accepting cycle.
  logic [ADDR_W-1:0]  fl_mem [LL_DEPTH];
  logic [ADDR_W-1:0]  fl_rd_ptr_q, fl_rd_ptr_d;
  logic [ADDR_W-1:0]  fl_wr_ptr_q, fl_wr_ptr_d;
  logic               fl_we;
  logic [ADDR_W-1:0]  fl_waddr, fl_wdata;

  logic [ADDR_W-1:0]  head_q [NUM_QUEUES];
  logic [ADDR_W-1:0]  head_d [NUM_QUEUES];
  logic [ADDR_W-1:0]  tail_q [NUM_QUEUES];
  logic [ADDR_W-1:0]  tail_d [NUM_QUEUES];
  logic [CNT_W-1:0]   cnt_q  [NUM_QUEUES];
  logic [CNT_W-1:0]   cnt_d  [NUM_QUEUES];
  logic [CNT_W-1:0]   gcnt_q, gcnt_d;

  // In-flight dequeues, aligned with the storage read latency. upd marks
  // entries whose next-pointer result must become the new queue head; it is
  // clear when the queue ran empty or a same-cycle enqueue already set head.
  deq_pipe_t               pipe_q [READ_DELAY];
  deq_pipe_t               pipe_d [READ_DELAY];
  logic [READ_DELAY-1:0]   upd_q, upd_d;
  deq_pipe_t               out_q, out_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

  logic [NUM_QUEUES-1:0]   inflight, deq_rdy;
  logic                    enq_rdy, enq_acc, deq_acc;
  logic [ADDR_W-1:0]       alloc_addr, deq_head;
  logic [DATA_WIDTH-1:0]   ram_data_rd;
  logic [ADDR_W-1:0]       ram_next_rd;
  logic                    next_we;

  assign alloc_addr = fl_mem[fl_rd_ptr_q];
  assign deq_head   = head_q[deq_id_in];

  // Full check uses the registered count only; a node released this cycle
  // becomes usable one cycle later.
  assign enq_rdy = init_done_q && (gcnt_q < CNT_W'(LL_DEPTH));
  assign enq_acc = enq_vld_in && enq_rdy;
  assign deq_acc = deq_vld_in && (int'(deq_id_in) < NUM_QUEUES) && deq_rdy[deq_id_in];

  always_comb begin
    inflight = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      for (int s = 0; s < READ_DELAY; s++) begin
        if (pipe_q[s].vld && (pipe_q[s].qid == QID_W'(q))) begin
          inflight[q] = 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_queue
    assign deq_rdy[gi] = init_done_q && (cnt_q[gi] != '0) && !inflight[gi];
    assign queue_cnt_out[gi*CNT_W +: CNT_W] = cnt_q[gi];
  end

  // Control: init sequencing, free list, head/tail/count bookkeeping.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    fl_rd_ptr_d = fl_rd_ptr_q;
    fl_wr_ptr_d = fl_wr_ptr_q;
    fl_we       = 1'b0;
    fl_waddr    = init_cnt_q;
    fl_wdata    = init_cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    next_we     = 1'b0;

    case (state_q)
      INIT: begin
        fl_we      = 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == ADDR_W'(LL_DEPTH - 1)) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        if (out_q.vld) begin
          fl_we       = 1'b1;
          fl_waddr    = fl_wr_ptr_q;
          fl_wdata    = out_q.addr;
          fl_wr_ptr_d = fl_wr_ptr_q + 1'b1;
        end
      end
      default: state_d = INIT;
    endcase

    if (enq_acc) begin
      fl_rd_ptr_d = fl_rd_ptr_q + 1'b1;
      // A queue draining its last node in this same cycle is treated as empty.
      if ((cnt_q[enq_id_in] == '0) ||
          (deq_acc && (deq_id_in == enq_id_in) && (cnt_q[enq_id_in] == CNT_W'(1)))) begin
        head_d[enq_id_in] = alloc_addr;
      end else begin
        next_we = 1'b1;
      end
      tail_d[enq_id_in] = alloc_addr;
    end

    if (pipe_q[READ_DELAY-1].vld && upd_q[READ_DELAY-1]) begin
      head_d[pipe_q[READ_DELAY-1].qid] = ram_next_rd;
    end

    for (int q = 0; q < NUM_QUEUES; q++) begin
      cnt_d[q] = cnt_q[q]
               + CNT_W'(enq_acc && (enq_id_in == QID_W'(q)))
               - CNT_W'(deq_acc && (deq_id_in == QID_W'(q)));
    end
  end

  assign gcnt_d = gcnt_q + CNT_W'(enq_acc) - CNT_W'(out_q.vld);

  // Dequeue pipeline.
  always_comb begin
    pipe_d[0].vld  = deq_acc;
    pipe_d[0].qid  = deq_acc ? deq_id_in : '0;
    pipe_d[0].addr = deq_acc ? deq_head : '0;
    upd_d          = '0;
    upd_d[0]       = deq_acc && (cnt_q[deq_id_in] > CNT_W'(1));
    for (int s = 1; s < READ_DELAY; s++) begin
      pipe_d[s] = pipe_q[s-1];
      upd_d[s]  = upd_q[s-1];
    end
    out_d      = pipe_q[READ_DELAY-1];
    out_data_d = pipe_q[READ_DELAY-1].vld ? ram_data_rd : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      fl_rd_ptr_q <= '0;
      fl_wr_ptr_q <= '0;
      gcnt_q      <= '0;
      upd_q       <= '0;
      out_q       <= '0;
      out_data_q  <= '0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
        head_q[q] <= '0;
        tail_q[q] <= '0;
        cnt_q[q]  <= '0;
      end
      for (int s = 0; s < READ_DELAY; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      fl_rd_ptr_q <= fl_rd_ptr_d;
      fl_wr_ptr_q <= fl_wr_ptr_d;
      gcnt_q      <= gcnt_d;
      upd_q       <= upd_d;
      out_q       <= out_d;
      out_data_q  <= out_data_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      pipe_q      <= pipe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fl_we) begin
      fl_mem[fl_waddr] <= fl_wdata;
    end
  end

  ll_delay_ram #(
    .DEPTH (LL_DEPTH),
    .WIDTH (DATA_WIDTH),
    .DELAY (READ_DELAY)
  ) u_data_ram (
    .clk   (clk),
    .we    (enq_acc),
    .waddr (alloc_addr),
    .wdata (enq_data_in),
    .raddr (deq_head),
    .rdata (ram_data_rd)
  );

  ll_delay_ram #(
    .DEPTH (LL_DEPTH),
    .WIDTH (ADDR_W),
    .DELAY (READ_DELAY)
  ) u_next_ram (
    .clk   (clk),
    .we    (next_we),
    .waddr (tail_q[enq_id_in]),
    .wdata (alloc_addr),
    .raddr (deq_head),
    .rdata (ram_next_rd)
  );

`ifdef MQ_LL_ERR_EN
  logic enq_ovf_q, enq_ovf_d;
  logic deq_udf_q, deq_udf_d;

  assign enq_ovf_d = enq_ovf_q || (enq_vld_in && !enq_rdy && init_done_q);
  assign deq_udf_d = deq_udf_q ||
                     (deq_vld_in && !deq_rdy[deq_id_in] && init_done_q &&
                      (cnt_q[deq_id_in] == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enq_ovf_q <= 1'b0;
      deq_udf_q <= 1'b0;
    end else begin
      enq_ovf_q <= enq_ovf_d;
      deq_udf_q <= deq_udf_d;
    end
  end

  assign enq_ovf_err_out = enq_ovf_q;
  assign deq_udf_err_out = deq_udf_q;
`endif

  assign init_done      = init_done_q;
  assign enq_rdy_out    = enq_rdy;
  assign deq_rdy_out    = deq_rdy;
  assign deq_vld_out    = out_q.vld;
  assign deq_id_out     = out_q.qid;
  assign deq_data_out   = out_data_q;
  assign global_cnt_out = gcnt_q;

endmodule

// File: tb/tb_mq_linked_list_pipe.sv
// ---------------------------------------------------------------------------
// tb_mq_linked_list_pipe
// Directed scenarios followed by randomized traffic, all checked each cycle
// against a queue-level reference model (per-queue data queues, a list of
// expected outputs with due cycles, and a node count). Define MQ_LL_ERR_EN
// to also check the sticky error outputs.
// ---------------------------------------------------------------------------
module tb_mq_linked_list_pipe;

  localparam int NQ    = 4;
  localparam int DEPTH = 16;
  localparam int DW    = 4;
  localparam int RD    = 3;
  localparam int CW    = 5;
  localparam int QW    = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            init_done;
  logic            enq_vld_in = 1'b0;
  logic            enq_rdy_out;
  logic [QW-1:0]   enq_id_in = '0;
  logic [DW-1:0]   enq_data_in = '0;
  logic            deq_vld_in = 1'b0;
  logic [NQ-1:0]   deq_rdy_out;
  logic [QW-1:0]   deq_id_in = '0;
  logic            deq_vld_out;
  logic [QW-1:0]   deq_id_out;
  logic [DW-1:0]   deq_data_out;
  logic [NQ*CW-1:0] queue_cnt_out;
  logic [CW-1:0]   global_cnt_out;
`ifdef MQ_LL_ERR_EN
  logic            enq_ovf_err_out;
  logic            deq_udf_err_out;
`endif

  mq_linked_list_pipe dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .init_done      (init_done),
    .enq_vld_in     (enq_vld_in),
    .enq_rdy_out    (enq_rdy_out),
    .enq_id_in      (enq_id_in),
    .enq_data_in    (enq_data_in),
    .deq_vld_in     (deq_vld_in),
    .deq_rdy_out    (deq_rdy_out),
    .deq_id_in      (deq_id_in),
    .deq_vld_out    (deq_vld_out),
    .deq_id_out     (deq_id_out),
    .deq_data_out   (deq_data_out),
`ifdef MQ_LL_ERR_EN
    .enq_ovf_err_out(enq_ovf_err_out),
    .deq_udf_err_out(deq_udf_err_out),
`endif
    .queue_cnt_out  (queue_cnt_out),
    .global_cnt_out (global_cnt_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int due;
    int id;
    int data;
  } exp_t;

  int   mq [NQ][$];       // payloads per queue, oldest first
  exp_t exp_q [$];        // outputs still to appear, in acceptance order
  int   last_acc [NQ];    // cycle of the latest accepted dequeue per queue
  int   m_gcnt;           // nodes held incl. awaiting release
  int   cyc;
  bit   ovf_exp, udf_exp;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int q = 0; q < NQ; q++) begin
      mq[q].delete();
      last_acc[q] = -100;
    end
    exp_q.delete();
    m_gcnt  = 0;
    ovf_exp = 1'b0;
    udf_exp = 1'b0;
  endtask

  // One clock cycle: check every output against the model, drive the
  // request, advance the model by the outcome the rules dictate.
  task automatic step(input bit ev, input int eid, input int edat, input bit dv, input int did);
    bit   m_enq_rdy;
    bit   m_rdy [NQ];
    bit   exp_out;
    int   d;
    exp_t e;
    m_enq_rdy = (m_gcnt < DEPTH);
    check_eq("enq_rdy", enq_rdy_out, m_enq_rdy);
    check_eq("global_cnt", global_cnt_out, m_gcnt);
    for (int q = 0; q < NQ; q++) begin
      m_rdy[q] = (mq[q].size() > 0) && ((cyc - last_acc[q]) > RD);
      check_eq($sformatf("deq_rdy[%0d]", q), deq_rdy_out[q], m_rdy[q]);
      check_eq($sformatf("queue_cnt[%0d]", q), queue_cnt_out[q*CW +: CW], mq[q].size());
    end
    exp_out = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check_eq("deq_vld_out", deq_vld_out, exp_out);
    if (exp_out) begin
      check_eq("deq_id_out", deq_id_out, exp_q[0].id);
      check_eq("deq_data_out", deq_data_out, exp_q[0].data);
      $display("[TB] cyc %0d deq q%0d data %0d", cyc, deq_id_out, deq_data_out);
    end
`ifdef MQ_LL_ERR_EN
    check_eq("enq_ovf_err", enq_ovf_err_out, ovf_exp);
    check_eq("deq_udf_err", deq_udf_err_out, udf_exp);
`endif
    enq_vld_in  = ev;
    enq_id_in   = QW'(eid);
    enq_data_in = DW'(edat);
    deq_vld_in  = dv;
    deq_id_in   = QW'(did);
    @(posedge clk);
    if (exp_out) begin
      void'(exp_q.pop_front());
      m_gcnt--;
    end
    if (dv && m_rdy[did]) begin
      d      = mq[did].pop_front();
      e.due  = cyc + RD + 1;
      e.id   = did;
      e.data = d;
      exp_q.push_back(e);
      last_acc[did] = cyc;
    end else if (dv && mq[did].size() == 0) begin
      udf_exp = 1'b1;
    end
    if (ev && m_enq_rdy) begin
      mq[eid].push_back(edat);
      m_gcnt++;
    end else if (ev) begin
      ovf_exp = 1'b1;
    end
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0, 1'b0, 0);
  endtask

  // Assert reset, check the cleared outputs, release and time the init.
  task automatic apply_reset();
    reset_n     = 1'b0;
    enq_vld_in  = 1'b0;
    deq_vld_in  = 1'b0;
    enq_id_in   = '0;
    deq_id_in   = '0;
    enq_data_in = '0;
    #1;
    check_eq("rst deq_vld_out", deq_vld_out, 0);
    check_eq("rst deq_id_out", deq_id_out, 0);
    check_eq("rst deq_data_out", deq_data_out, 0);
    check_eq("rst init_done", init_done, 0);
    check_eq("rst enq_rdy", enq_rdy_out, 0);
    check_eq("rst deq_rdy", deq_rdy_out, 0);
    check_eq("rst global_cnt", global_cnt_out, 0);
    check_eq("rst queue_cnt", queue_cnt_out, 0);
`ifdef MQ_LL_ERR_EN
    check_eq("rst enq_ovf_err", enq_ovf_err_out, 0);
    check_eq("rst deq_udf_err", deq_udf_err_out, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      check_eq($sformatf("init_done@%0d", k), init_done, (k == DEPTH));
      if (k == DEPTH - 1) check_eq("enq_rdy before init", enq_rdy_out, 0);
    end
    check_eq("enq_rdy after init", enq_rdy_out, 1);
  endtask

  int ph, pe, pd, qmax;

  initial begin
    cyc = 0;
    model_clear();
    #2;
    apply_reset();

    // Two items through queue 0.
    step(1, 0, 1, 0, 0);
    step(1, 0, 2, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 0);
    idle(5);
    step(0, 0, 0, 1, 0);
    idle(6);

    // Fill all 16 nodes, overflow attempt, then one release while pushing.
    for (int i = 0; i < DEPTH; i++) step(1, i % NQ, i, 0, 0);
    step(1, 0, 5, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(1, 1, 3, 0, 0);
    for (int i = 0; i < 44; i++) step(0, 0, 0, 1, i % NQ);
    idle(6);

    // Same-queue enqueue + dequeue with a single node held.
    step(1, 2, 7, 0, 0);
    idle(1);
    step(1, 2, 9, 1, 2);
    idle(5);
    step(0, 0, 0, 1, 2);
    idle(6);

    // Back-to-back dequeues on queue 1 with queue 3 interleaved.
    step(1, 1, 5, 0, 0);
    step(1, 1, 6, 0, 0);
    step(1, 1, 4, 0, 0);
    step(1, 3, 8, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 3);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);
    idle(6);

    // Randomized traffic in phases: fill, two-queue churn, drain, single queue.
    for (int i = 0; i < 2400; i++) begin
      ph = (i / 200) % 4;
      case (ph)
        0:       begin pe = 80; pd = 25; qmax = 3; end
        1:       begin pe = 55; pd = 60; qmax = 1; end
        2:       begin pe = 20; pd = 85; qmax = 3; end
        default: begin pe = 60; pd = 60; qmax = 0; end
      endcase
      step($urandom_range(99) < pe, $urandom_range(qmax), $urandom_range(15),
           $urandom_range(99) < pd, $urandom_range(qmax));
    end
    idle(8);

    // Reset while two dequeues are in flight.
    step(1, 0, 11, 0, 0);
    step(1, 1, 12, 0, 0);
    idle(1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    idle(2);
    check_eq("pre-reset deq_vld_out", deq_vld_out, (exp_q.size() > 0) && (exp_q[0].due == cyc));
    apply_reset();

    // Dequeue from empty queue 0 after re-init (sets the underflow flag
    // when the error outputs are built in).
    step(0, 0, 0, 1, 0);
    idle(3);

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(99) < 60, $urandom_range(3), $urandom_range(15),
           $urandom_range(99) < 55, $urandom_range(3));
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
